// File: rtl/fetch_pc_predict_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pc_predict_pkg : widths, opcodes and counter helpers for fetch/predict
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fetch_pc_predict_pkg;

  localparam int          PC_WIDTH     = 32;
  localparam int          INSTR_WIDTH  = 32;
  localparam int          HIST_WIDTH   = 8;
  localparam logic [6:0]  OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0]  OPC_JAL      = 7'b1101111;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [1:0]  CTR_INIT     = 2'b01;

  typedef enum logic [1:0] {
    PD_SEQ    = 2'd0,
    PD_BRANCH = 2'd1,
    PD_JAL    = 2'd2
  } pd_kind_e;

  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == 2'b11) ? ctr : ctr + 2'd1;
    else       return (ctr == 2'b00) ? ctr : ctr - 2'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_pc_predict_bpred_table.sv
// ---------------------------------------------------------------------------
// bpred_table : 2-bit saturating counter array, combinational read, one write
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bpred_table
  import fetch_pc_predict_pkg::*;
#(
  parameter int HIST_W = HIST_WIDTH
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic [HIST_W-1:0] rd_idx_i,
  output logic [1:0]        rd_ctr_o,
  input  logic              wr_en_i,
  input  logic [HIST_W-1:0] wr_idx_i,
  input  logic              wr_taken_i
);

  localparam int DEPTH = 1 << HIST_W;

  logic [1:0] ctr_q [DEPTH];

  // Read is combinational from the current array, so a same-cycle write is not seen.
  assign rd_ctr_o = ctr_q[rd_idx_i];

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ctr_q[i] <= CTR_INIT;
    end else if (wr_en_i) begin
      ctr_q[wr_idx_i] <= ctr_next(ctr_q[wr_idx_i], wr_taken_i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_pc_predict.sv
// ---------------------------------------------------------------------------
// fetch_pc_predict : fetch PC/GHR, pre-decode and gshare/bimodal prediction
// Optional macro GSHARE_EN: XOR the GHR into the table index. Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_pc_predict
  import fetch_pc_predict_pkg::*;
#(
  parameter int              PC_W     = PC_WIDTH,
  parameter int              HIST_W   = HIST_WIDTH,
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic [PC_W-1:0]   instr_i,
  input  logic              F_stall_i,
  input  logic              E_redirect_i,
  input  logic [PC_W-1:0]   E_redirect_PC_i,
  input  logic              E_train_vaild_i,
  input  logic              E_train_taken_i,
  input  logic [PC_W-1:0]   E_train_PC_i,
  input  logic [HIST_W-1:0] E_train_history_i,
  output logic [PC_W-1:0]   F_PC_o,
  output logic [PC_W-1:0]   F_nPC_o,
  output logic              F_train_predict_o,
  output logic              F_train_vaild_o,
  output logic [HIST_W-1:0] F_train_history_o,
  output logic              F_commit_o
);

  logic [PC_W-1:0]   pc_q, pc_d;
  logic [HIST_W-1:0] ghr_q, ghr_d;
  logic              commit_q;

  pd_kind_e          kind;
  logic [PC_W-1:0]   b_imm, j_imm, pc_plus4;
  logic [HIST_W-1:0] rd_idx, wr_idx;
  logic [1:0]        rd_ctr;
  logic              predict;
  logic              unused_train_pc;

  always_comb begin
    kind = PD_SEQ;
    if (instr_i[6:0] == OPC_BRANCH)   kind = PD_BRANCH;
    else if (instr_i[6:0] == OPC_JAL) kind = PD_JAL;
  end

  assign b_imm    = {{(PC_W-12){instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign j_imm    = {{(PC_W-20){instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
  assign pc_plus4 = pc_q + PC_W'(4);

`ifdef GSHARE_EN
  assign rd_idx = pc_q[HIST_W+1:2] ^ ghr_q;
  assign wr_idx = E_train_PC_i[HIST_W+1:2] ^ E_train_history_i;
`else
  assign rd_idx = pc_q[HIST_W+1:2];
  assign wr_idx = E_train_PC_i[HIST_W+1:2];
`endif

  assign unused_train_pc = ^{E_train_PC_i[PC_W-1:HIST_W+2], E_train_PC_i[1:0]};

  bpred_table #(.HIST_W(HIST_W)) u_table (
    .clk_i      (clk_i),
    .rst_n      (rst_n),
    .rd_idx_i   (rd_idx),
    .rd_ctr_o   (rd_ctr),
    .wr_en_i    (E_train_vaild_i),
    .wr_idx_i   (wr_idx),
    .wr_taken_i (E_train_taken_i)
  );

  assign predict = rd_ctr[1];

  always_comb begin
    F_nPC_o           = pc_plus4;
    F_train_predict_o = 1'b0;
    case (kind)
      PD_BRANCH: begin
        F_train_predict_o = predict;
        if (predict) F_nPC_o = pc_q + b_imm;
      end
      PD_JAL: begin
        F_train_predict_o = 1'b1;
        F_nPC_o           = pc_q + j_imm;
      end
      default: ;
    endcase
  end

  // Redirect wins over stall; the GHR is rebuilt from the resolved branch snapshot.
  always_comb begin
    pc_d  = pc_q;
    ghr_d = ghr_q;
    if (E_redirect_i) begin
      pc_d  = E_redirect_PC_i;
      ghr_d = E_train_vaild_i ? {E_train_history_i[HIST_W-2:0], E_train_taken_i}
                              : E_train_history_i;
    end else if (!F_stall_i) begin
      pc_d = F_nPC_o;
      if (kind == PD_BRANCH) ghr_d = {ghr_q[HIST_W-2:0], predict};
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      ghr_q    <= '0;
      commit_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      ghr_q    <= ghr_d;
      commit_q <= 1'b1;
    end
  end

  assign F_PC_o            = pc_q;
  assign F_train_vaild_o   = (kind == PD_BRANCH);
  assign F_train_history_o = ghr_q;
  assign F_commit_o        = commit_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_pc_predict.sv
// ---------------------------------------------------------------------------
// tb_fetch_pc_predict : directed self-checking bench for fetch_pc_predict
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fetch_pc_predict;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] JAL20 = 32'h0200_00EF;  // jal x1, +0x20
  localparam logic [31:0] BEQ40 = 32'h0400_0063;  // beq x0, x0, +0x40

  logic        clk_i = 1'b0;
  logic        rst_n;
  logic [31:0] instr_i;
  logic        F_stall_i;
  logic        E_redirect_i;
  logic [31:0] E_redirect_PC_i;
  logic        E_train_vaild_i;
  logic        E_train_taken_i;
  logic [31:0] E_train_PC_i;
  logic [7:0]  E_train_history_i;
  logic [31:0] F_PC_o;
  logic [31:0] F_nPC_o;
  logic        F_train_predict_o;
  logic        F_train_vaild_o;
  logic [7:0]  F_train_history_o;
  logic        F_commit_o;

  int n_cmp = 0;
  int n_err = 0;

  fetch_pc_predict dut (
    .clk_i             (clk_i),
    .rst_n             (rst_n),
    .instr_i           (instr_i),
    .F_stall_i         (F_stall_i),
    .E_redirect_i      (E_redirect_i),
    .E_redirect_PC_i   (E_redirect_PC_i),
    .E_train_vaild_i   (E_train_vaild_i),
    .E_train_taken_i   (E_train_taken_i),
    .E_train_PC_i      (E_train_PC_i),
    .E_train_history_i (E_train_history_i),
    .F_PC_o            (F_PC_o),
    .F_nPC_o           (F_nPC_o),
    .F_train_predict_o (F_train_predict_o),
    .F_train_vaild_o   (F_train_vaild_o),
    .F_train_history_o (F_train_history_o),
    .F_commit_o        (F_commit_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    E_redirect_i      = 1'b1;
    E_redirect_PC_i   = pc;
    E_train_vaild_i   = 1'b0;
    E_train_history_i = 8'h00;
    tick();
    E_redirect_i      = 1'b0;
  endtask

  initial begin
    int bad;
    rst_n             = 1'b0;
    instr_i           = NOP;
    F_stall_i         = 1'b0;
    E_redirect_i      = 1'b0;
    E_redirect_PC_i   = '0;
    E_train_vaild_i   = 1'b0;
    E_train_taken_i   = 1'b0;
    E_train_PC_i      = '0;
    E_train_history_i = '0;
    #2;
    chk("rst_pc", F_PC_o, 32'h0);
    chk("rst_commit", 32'(F_commit_o), 32'h0);
    chk("rst_hist", 32'(F_train_history_o), 32'h0);

    @(negedge clk_i);
    rst_n = 1'b1;
    #1;
    chk("seq_pc0", F_PC_o, 32'h0);
    chk("seq_npc0", F_nPC_o, 32'h4);
    chk("seq_vaild", 32'(F_train_vaild_o), 32'h0);
    chk("seq_commit0", 32'(F_commit_o), 32'h0);
    tick();
    chk("seq_pc1", F_PC_o, 32'h4);
    chk("seq_commit1", 32'(F_commit_o), 32'h1);
    tick();
    chk("seq_pc2", F_PC_o, 32'h8);

    // JAL at 0x10
    redirect_to(32'h10);
    chk("jal_pc", F_PC_o, 32'h10);
    instr_i = JAL20;
    #1;
    chk("jal_npc", F_nPC_o, 32'h30);
    chk("jal_pred", 32'(F_train_predict_o), 32'h1);
    chk("jal_vaild", 32'(F_train_vaild_o), 32'h0);
    tick();
    chk("jal_next_pc", F_PC_o, 32'h30);
    chk("jal_ghr", 32'(F_train_history_o), 32'h0);

    // B-type at 0x100, weakly not-taken, then trained taken twice
    instr_i = NOP;
    redirect_to(32'h100);
    instr_i = BEQ40;
    F_stall_i = 1'b1;
    #1;
    chk("br_vaild", 32'(F_train_vaild_o), 32'h1);
    chk("br_pred0", 32'(F_train_predict_o), 32'h0);
    chk("br_npc0", F_nPC_o, 32'h104);
    E_train_vaild_i   = 1'b1;
    E_train_taken_i   = 1'b1;
    E_train_PC_i      = 32'h100;
    E_train_history_i = 8'h00;
    #1;
    chk("br_rbw", 32'(F_train_predict_o), 32'h0);
    tick();
    chk("br_pred1", 32'(F_train_predict_o), 32'h1);
    chk("br_stall_pc", F_PC_o, 32'h100);
    tick();
    E_train_vaild_i = 1'b0;
    F_stall_i       = 1'b0;
    #1;
    chk("br_npc2", F_nPC_o, 32'h140);
    tick();
    chk("br_next_pc", F_PC_o, 32'h140);
    chk("br_ghr", 32'(F_train_history_o), 32'h01);

    // Redirect and stall together, with training
    instr_i           = NOP;
    F_stall_i         = 1'b1;
    E_redirect_i      = 1'b1;
    E_redirect_PC_i   = 32'h200;
    E_train_vaild_i   = 1'b1;
    E_train_taken_i   = 1'b1;
    E_train_PC_i      = 32'h200;
    E_train_history_i = 8'h5A;
    tick();
    E_redirect_i    = 1'b0;
    E_train_vaild_i = 1'b0;
    chk("redir_pc", F_PC_o, 32'h200);
    chk("redir_ghr", 32'(F_train_history_o), 32'hB5);
    F_stall_i = 1'b0;

    // Saturation: six taken trainings on PC 0x300
    redirect_to(32'h300);
    instr_i           = BEQ40;
    F_stall_i         = 1'b1;
    E_train_vaild_i   = 1'b1;
    E_train_taken_i   = 1'b1;
    E_train_PC_i      = 32'h300;
    E_train_history_i = 8'h00;
    for (int k = 0; k < 6; k++) tick();
    chk("sat_ctr", 32'(dut.u_table.ctr_q[8'hC0]), 32'h3);
    chk("sat_pred", 32'(F_train_predict_o), 32'h1);
    E_train_taken_i = 1'b0;
    tick();
    chk("sat_nt1_pred", 32'(F_train_predict_o), 32'h1);
    tick();
    chk("sat_nt2_pred", 32'(F_train_predict_o), 32'h0);
    E_train_vaild_i = 1'b0;
    F_stall_i       = 1'b0;
    chk("sat_pc_held", F_PC_o, 32'h300);

    // Asynchronous reset mid-run with training in flight
    E_train_vaild_i = 1'b1;
    E_train_taken_i = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_pc", F_PC_o, 32'h0);
    chk("arst_commit", 32'(F_commit_o), 32'h0);
    chk("arst_ghr", 32'(F_train_history_o), 32'h0);
    chk("arst_pred", 32'(F_train_predict_o), 32'h0);
    bad = 0;
    for (int i = 0; i < 256; i++)
      if (dut.u_table.ctr_q[i] !== 2'b01) bad++;
    chk("arst_ctrs", 32'(bad), 32'h0);
    E_train_vaild_i = 1'b0;
    instr_i = NOP;
    @(negedge clk_i);
    rst_n = 1'b1;
    tick();
    chk("post_rst_pc", F_PC_o, 32'h4);
    chk("post_rst_commit", 32'(F_commit_o), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
